// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit.
// Holds the memory operation encoding, the RAM size codes, the FSM state
// encoding and two small helpers used when a request is accepted.
// No ports (package).
package mips_mem_pkg;

    // Operation codes on req_op; code 3'd7 is undefined and is rejected
    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LHU = 3'd2,
        OP_LBU = 3'd3,
        OP_SW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6
    } mem_op_e;

    // Size codes driven on ram_size; the RAM does the load extension itself
    localparam logic [1:0] SIZE_WORD   = 2'd0;
    localparam logic [1:0] SIZE_BYTE_S = 2'd1;
    localparam logic [1:0] SIZE_HALF_U = 2'd2;
    localparam logic [1:0] SIZE_BYTE_U = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    // Store data is right-aligned; the unused upper bits are forced to zero
    function automatic logic [31:0] store_format(input logic [2:0] op,
                                                 input logic [31:0] wdata);
        logic [31:0] data;
        case (op)
            OP_SW:   data = wdata;
            OP_SH:   data = {16'h0, wdata[15:0]};
            OP_SB:   data = {24'h0, wdata[7:0]};
            default: data = 32'h0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the RAM bus seen by
// the load/store unit.
//   req_valid/req_ready/req_op/req_adr/req_wdata : pipeline request
//   resp_valid/resp_data/resp_err                : one-cycle response
//   ram_read/ram_write/ram_size/ram_adr/ram_data : RAM strobes and address/data
//   ram_word                                     : RAM read data (pre-extended)
// The slave modport is the unit; the master modport is the pipeline plus RAM.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    logic        ram_read;
    logic        ram_write;
    logic [1:0]  ram_size;
    logic [31:0] ram_adr;
    logic [31:0] ram_data;
    logic [31:0] ram_word;

    modport master (
        output req_valid, req_op, req_adr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        input  ram_read, ram_write, ram_size, ram_adr, ram_data,
        output ram_word
    );

    modport slave (
        input  req_valid, req_op, req_adr, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        output ram_read, ram_write, ram_size, ram_adr, ram_data,
        input  ram_word
    );

endinterface

// File: rtl/lsu_align_chk.sv
// Combinational decode of a memory operation into its RAM size code and an
// alignment verdict.
//   op         : operation code (mem_op_e encoding, 3'd7 undefined)
//   adr_lo     : low two bits of the byte address
//   size       : ram_size code for the operation
//   misaligned : access cannot be performed (bad alignment or undefined op)
module lsu_align_chk
    import mips_mem_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] adr_lo,
    output logic [1:0] size,
    output logic       misaligned
);

    // Undefined opcodes fall through to the default and are reported as
    // misaligned so that they produce an error response without RAM traffic.
    always_comb begin
        size       = SIZE_WORD;
        misaligned = 1'b1;
        case (op)
            OP_LW, OP_SW: begin
                size       = SIZE_WORD;
                misaligned = (adr_lo != 2'b00);
            end
            OP_LB, OP_SB: begin
                size       = SIZE_BYTE_S;
                misaligned = 1'b0;
            end
            OP_LHU, OP_SH: begin
                size       = SIZE_HALF_U;
                misaligned = adr_lo[0];
            end
            OP_LBU: begin
                size       = SIZE_BYTE_U;
                misaligned = 1'b0;
            end
            default: begin
                size       = SIZE_WORD;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit sitting between a pipeline and a simple RAM.
// Accepts one request at a time in IDLE, checks alignment, runs a read of
// RAM_LAT cycles or a single-cycle write, then returns a one-cycle response.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : mem_access_unit_if.slave (request, response and RAM bus)
// Parameter RAM_LAT (1..15): cycles ram_read is held before ram_word is taken.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_unit_if.slave     bus
);

    localparam logic [3:0] LAT_INIT = 4'(RAM_LAT);

    lsu_state_e  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [1:0]  chk_size;
    logic        chk_misaligned;

    lsu_align_chk u_align_chk (
        .op         (bus.req_op),
        .adr_lo     (bus.req_adr[1:0]),
        .size       (chk_size),
        .misaligned (chk_misaligned)
    );

    // Next-state logic. The request is captured only in IDLE, so later input
    // changes have no effect. rdata is cleared on acceptance, which makes
    // store and error responses return zero without extra muxing.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    adr_d   = bus.req_adr;
                    wdata_d = store_format(bus.req_op, bus.req_wdata);
                    size_d  = chk_size;
                    err_d   = chk_misaligned;
                    rdata_d = 32'h0;
                    cnt_d   = 4'd0;
                    if (chk_misaligned) begin
                        state_d = RESP;
                    end else if (is_store(bus.req_op)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            RD: begin
                // The last read cycle is the one where the counter reads 1
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = bus.ram_word;
                    state_d = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state alone, and everything is forced to
    // zero while reset is held so nothing leaks out before the reset edge.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'h0;
        bus.resp_err   = 1'b0;
        bus.ram_read   = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ram_size   = 2'd0;
        bus.ram_adr    = 32'h0;
        bus.ram_data   = 32'h0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    bus.req_ready = 1'b1;
                end
                RD: begin
                    bus.ram_read = 1'b1;
                    bus.ram_size = size_q;
                    bus.ram_adr  = adr_q;
                end
                WR: begin
                    bus.ram_write = 1'b1;
                    bus.ram_size  = size_q;
                    bus.ram_adr   = adr_q;
                    bus.ram_data  = wdata_q;
                end
                RESP: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = rdata_q;
                    bus.resp_err   = err_q;
                end
                default: begin
                    bus.req_ready = 1'b0;
                end
            endcase
        end
    end

    // State register; reset abandons any access in flight without a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'd0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Two instances share clock and reset: dut0 with RAM_LAT=1 and dut1 with
// RAM_LAT=3. A byte-addressed big-endian RAM model serves both; only dut0
// issues stores. Directed vectors carry hand-computed expected values.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst;
    logic        dut_sel;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;

    logic        o_ready, o_read, o_write, o_resp_valid, o_resp_err;
    logic [1:0]  o_size;
    logic [31:0] o_adr, o_ram_data, o_resp_data;

    logic [7:0]  mem [0:255];
    bit          mem_loaded = 1'b0;

    int vec_count;
    int miscompare_count;

    mem_access_unit_if if0 ();
    mem_access_unit_if if1 ();

    mem_access_unit #(.RAM_LAT(LAT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    mem_access_unit #(.RAM_LAT(LAT1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian read with the extension the RAM is expected to perform
    function automatic logic [31:0] readRam(input logic [31:0] adr, input logic [1:0] size);
        logic [7:0] a;
        logic [31:0] w;
        a = adr[7:0];
        case (size)
            2'd0:    w = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
            2'd1:    w = {{24{mem[a][7]}}, mem[a]};
            2'd2:    w = {16'h0, mem[a], mem[a + 8'd1]};
            default: w = {24'h0, mem[a]};
        endcase
        return w;
    endfunction

    // Request fan-out to the selected instance and RAM read data
    always_comb begin
        if0.req_valid = req_valid && !dut_sel;
        if0.req_op    = req_op;
        if0.req_adr   = req_adr;
        if0.req_wdata = req_wdata;
        if1.req_valid = req_valid && dut_sel;
        if1.req_op    = req_op;
        if1.req_adr   = req_adr;
        if1.req_wdata = req_wdata;
        if0.ram_word  = readRam(if0.ram_adr, if0.ram_size);
        if1.ram_word  = readRam(if1.ram_adr, if1.ram_size);
    end

    // Observation mux onto the selected instance
    always_comb begin
        o_ready      = dut_sel ? if1.req_ready  : if0.req_ready;
        o_read       = dut_sel ? if1.ram_read   : if0.ram_read;
        o_write      = dut_sel ? if1.ram_write  : if0.ram_write;
        o_size       = dut_sel ? if1.ram_size   : if0.ram_size;
        o_adr        = dut_sel ? if1.ram_adr    : if0.ram_adr;
        o_ram_data   = dut_sel ? if1.ram_data   : if0.ram_data;
        o_resp_valid = dut_sel ? if1.resp_valid : if0.resp_valid;
        o_resp_data  = dut_sel ? if1.resp_data  : if0.resp_data;
        o_resp_err   = dut_sel ? if1.resp_err   : if0.resp_err;
    end

    // RAM contents: byte i*4+3 holds i, byte 0x0A holds 0xAA, the rest 0.
    // Stores from dut0 land here big-endian.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= ((i % 4) == 3) ? 8'(i / 4) : 8'h00;
            end
            mem[8'h0A] <= 8'hAA;
            mem_loaded <= 1'b1;
        end else if (if0.ram_write) begin
            case (if0.ram_size)
                2'd0: begin
                    mem[if0.ram_adr[7:0]]         <= if0.ram_data[31:24];
                    mem[if0.ram_adr[7:0] + 8'd1]  <= if0.ram_data[23:16];
                    mem[if0.ram_adr[7:0] + 8'd2]  <= if0.ram_data[15:8];
                    mem[if0.ram_adr[7:0] + 8'd3]  <= if0.ram_data[7:0];
                end
                2'd2: begin
                    mem[if0.ram_adr[7:0]]         <= if0.ram_data[15:8];
                    mem[if0.ram_adr[7:0] + 8'd1]  <= if0.ram_data[7:0];
                end
                default: begin
                    mem[if0.ram_adr[7:0]]         <= if0.ram_data[7:0];
                end
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        vec_count++;
        if (got !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".ctl0"}, {27'h0, if0.req_ready, if0.resp_valid, if0.resp_err,
                                     if0.ram_read, if0.ram_write}, 32'h0);
        checkOutput({tag, ".bus0"}, if0.ram_adr | if0.ram_data | if0.resp_data |
                                    {30'h0, if0.ram_size}, 32'h0);
        checkOutput({tag, ".ctl1"}, {27'h0, if1.req_ready, if1.resp_valid, if1.resp_err,
                                     if1.ram_read, if1.ram_write}, 32'h0);
        checkOutput({tag, ".bus1"}, if1.ram_adr | if1.ram_data | if1.resp_data |
                                    {30'h0, if1.ram_size}, 32'h0);
    endtask

    // Presents one request to instance s and follows it to its response.
    // Called at posedge+1. With hold_valid the request stays asserted after
    // acceptance and the task returns in the response cycle, so the next call
    // presents its request while the unit is still busy.
    task automatic applyStimulus(input string name, input bit s, input logic [2:0] op,
                                 input logic [31:0] adr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input bit exp_err,
                                 input logic [1:0] exp_size, input logic [31:0] exp_ram_data,
                                 input int exp_wait, input bit hold_valid);
        int wait_cnt, resp_k, read_cnt, write_cnt, first_read, write_k;
        int exp_lat, exp_reads, exp_writes;
        bit overlap, busy_ready, leak, size_bad, adr_bad, wdata_bad;
        logic [31:0] got_data;
        logic got_err;

        dut_sel   = s;
        req_valid = 1'b1;
        req_op    = op;
        req_adr   = adr;
        req_wdata = wdata;
        #1;
        wait_cnt = 0;
        while (!o_ready && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        checkOutput({name, ".wait"}, wait_cnt, exp_wait);

        if (exp_err) begin
            exp_lat = 1; exp_reads = 0; exp_writes = 0;
        end else if (op >= 3'd4) begin
            exp_lat = 2; exp_reads = 0; exp_writes = 1;
        end else begin
            exp_reads  = s ? LAT1 : LAT0;
            exp_lat    = exp_reads + 1;
            exp_writes = 0;
        end

        @(posedge clk); #1;
        if (!hold_valid) begin
            req_valid = 1'b0;
            req_op    = 3'd7;
            req_adr   = 32'hFFFF_FFFD;
            req_wdata = ~wdata;
        end

        resp_k = 0; read_cnt = 0; write_cnt = 0; first_read = 0; write_k = 0;
        overlap = 0; busy_ready = 0; leak = 0; size_bad = 0; adr_bad = 0; wdata_bad = 0;
        got_data = 32'hx; got_err = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (o_ready) busy_ready = 1;
            if (o_read && o_write) overlap = 1;
            if (!o_write && o_ram_data != 32'h0) leak = 1;
            if (o_read) begin
                read_cnt++;
                if (first_read == 0) first_read = k;
                if (o_size != exp_size) size_bad = 1;
                if (o_adr != adr) adr_bad = 1;
            end
            if (o_write) begin
                write_cnt++;
                write_k = k;
                if (o_size != exp_size) size_bad = 1;
                if (o_adr != adr) adr_bad = 1;
                if (o_ram_data != exp_ram_data) wdata_bad = 1;
            end
            if (o_resp_valid) begin
                resp_k   = k;
                got_data = o_resp_data;
                got_err  = o_resp_err;
                break;
            end
            @(posedge clk); #1;
        end

        checkOutput({name, ".latency"}, resp_k, exp_lat);
        checkOutput({name, ".reads"}, read_cnt, exp_reads);
        checkOutput({name, ".writes"}, write_cnt, exp_writes);
        checkOutput({name, ".data"}, got_data, exp_data);
        checkOutput({name, ".err"}, {31'h0, got_err}, {31'h0, exp_err});
        checkOutput({name, ".overlap"}, {31'h0, overlap}, 32'h0);
        checkOutput({name, ".busyReady"}, {31'h0, busy_ready}, 32'h0);
        checkOutput({name, ".dataLeak"}, {31'h0, leak}, 32'h0);
        checkOutput({name, ".sizeStable"}, {31'h0, size_bad}, 32'h0);
        checkOutput({name, ".adrStable"}, {31'h0, adr_bad}, 32'h0);
        checkOutput({name, ".ramData"}, {31'h0, wdata_bad}, 32'h0);
        if (exp_reads > 0) checkOutput({name, ".firstRead"}, first_read, 1);
        if (exp_writes > 0) checkOutput({name, ".writeCycle"}, write_k, 1);

        if (!hold_valid) begin
            @(posedge clk); #1;
            checkOutput({name, ".pulse"}, {31'h0, o_resp_valid}, 32'h0);
            checkOutput({name, ".idle"}, {31'h0, o_ready}, 32'h1);
        end
    endtask

    initial begin
        bit stray;
        vec_count        = 0;
        miscompare_count = 0;
        rst       = 1'b0;
        dut_sel   = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_adr   = 32'h0;
        req_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b1;
        #1;
        checkOutput("reset.ready0", {31'h0, if0.req_ready}, 32'h1);
        checkOutput("reset.ready1", {31'h0, if1.req_ready}, 32'h1);

        // RAM_LAT = 1
        applyStimulus("lw08",  0, OP_LW,  32'h08, 32'h0,        32'h0000AA02, 0, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("lb0a",  0, OP_LB,  32'h0A, 32'h0,        32'hFFFFFFAA, 0, SIZE_BYTE_S, 32'h0,        0, 0);
        applyStimulus("lhu0a", 0, OP_LHU, 32'h0A, 32'h0,        32'h0000AA02, 0, SIZE_HALF_U, 32'h0,        0, 0);
        applyStimulus("lbu0a", 0, OP_LBU, 32'h0A, 32'h0,        32'h000000AA, 0, SIZE_BYTE_U, 32'h0,        0, 0);
        applyStimulus("lb0b",  0, OP_LB,  32'h0B, 32'h0,        32'h00000002, 0, SIZE_BYTE_S, 32'h0,        0, 0);
        applyStimulus("sb11",  0, OP_SB,  32'h11, 32'h12345678, 32'h0,        0, SIZE_BYTE_S, 32'h00000078, 0, 0);
        applyStimulus("lb11",  0, OP_LB,  32'h11, 32'h0,        32'h00000078, 0, SIZE_BYTE_S, 32'h0,        0, 0);
        applyStimulus("lw06",  0, OP_LW,  32'h06, 32'h0,        32'h0,        1, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("sh03",  0, OP_SH,  32'h03, 32'hFFFFFFFF, 32'h0,        1, SIZE_HALF_U, 32'h0,        0, 0);
        applyStimulus("lhu09", 0, OP_LHU, 32'h09, 32'h0,        32'h0,        1, SIZE_HALF_U, 32'h0,        0, 0);
        applyStimulus("op7",   0, 3'd7,   32'h00, 32'h0,        32'h0,        1, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("sw20",  0, OP_SW,  32'h20, 32'hCAFEF00D, 32'h0,        0, SIZE_WORD,   32'hCAFEF00D, 0, 0);
        applyStimulus("lw20",  0, OP_LW,  32'h20, 32'h0,        32'hCAFEF00D, 0, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("sh22",  0, OP_SH,  32'h22, 32'h1234BEEF, 32'h0,        0, SIZE_HALF_U, 32'h0000BEEF, 0, 0);
        applyStimulus("lw20b", 0, OP_LW,  32'h20, 32'h0,        32'hCAFEBEEF, 0, SIZE_WORD,   32'h0,        0, 0);

        // Back-to-back with req_valid held high
        applyStimulus("b2bA",  0, OP_LW,  32'h04, 32'h0,        32'h00000001, 0, SIZE_WORD,   32'h0,        0, 1);
        applyStimulus("b2bB",  0, OP_LW,  32'h0C, 32'h0,        32'h00000003, 0, SIZE_WORD,   32'h0,        1, 0);

        // RAM_LAT = 3
        applyStimulus("lat3lw0c", 1, OP_LW, 32'h0C, 32'h0,      32'h00000003, 0, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("lat3lb0a", 1, OP_LB, 32'h0A, 32'h0,      32'hFFFFFFAA, 0, SIZE_BYTE_S, 32'h0,        0, 0);

        // Reset in the middle of a read on the RAM_LAT=3 instance
        dut_sel   = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_adr   = 32'h0C;
        #1;
        checkOutput("rstMid.ready", {31'h0, o_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rstMid.rd1", {31'h0, o_read}, 32'h1);
        @(posedge clk); #1;
        checkOutput("rstMid.rd2", {31'h0, o_read}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("rstMid");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rstMid.release1", {31'h0, if1.req_ready}, 32'h1);
        checkOutput("rstMid.release0", {31'h0, if0.req_ready}, 32'h1);
        stray = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (if1.resp_valid || if1.ram_read || if1.ram_write || !if1.req_ready) stray = 1'b1;
        end
        checkOutput("rstMid.noResp", {31'h0, stray}, 32'h0);
        applyStimulus("rstLw04", 1, OP_LW, 32'h04, 32'h0,       32'h00000001, 0, SIZE_WORD,   32'h0,        0, 0);
        applyStimulus("rstLw04d0", 0, OP_LW, 32'h04, 32'h0,     32'h00000001, 0, SIZE_WORD,   32'h0,        0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
